bi_dir_piso_serializer: RTL

Parallel-in / serial-out companion to the team's bidirectional serial-in shift register. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock. Direction is selectable per word: right shift sends LSB first, left shift sends MSB first. It drives the serial input of the bidirectional SIPO, or any single-bit link, with framing strobes.

---
 rtl/bi_dir_piso_serializer_pkg.sv | 15 +
 rtl/bi_dir_piso_serializer.sv | 119 +++++++++++
 2 files changed

// File: rtl/bi_dir_piso_serializer_pkg.sv
// Shared definitions for the bidirectional PISO serializer and its SIPO companion.
// Holds the direction encoding, the FSM state type and the default word length.
package bi_dir_piso_serializer_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bi_dir_piso_serializer.sv
// Parallel-in / serial-out shifter with a valid/ready load port and per-word direction.
// Emits one bit per enabled clock with first/last framing strobes and a registered done pulse.
//
// state    | meaning
// ST_IDLE  | no frame; load port ready, serial outputs and strobes low
// ST_SHIFT | frame in progress; o_sd shows the current bit, cnt is its index
module bi_dir_piso_serializer
  import bi_dir_piso_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  input  logic             i_right,
  input  logic             i_en,
  output logic             o_sd,
  output logic             o_sd_valid,
  output logic             o_first,
  output logic             o_last,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             accept;
  logic             at_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      dir_q   <= DIR_LEFT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    dir_d        = dir_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    at_last      = (cnt_q == CNT_LAST);
    o_load_ready = 1'b0;
    o_sd         = 1'b0;
    o_sd_valid   = 1'b0;
    o_first      = 1'b0;
    o_last       = 1'b0;
    o_busy       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        o_load_ready = 1'b1;
      end
      ST_SHIFT: begin
        o_load_ready = at_last & i_en;
        o_sd         = (dir_q == DIR_RIGHT) ? shreg_q[0] : shreg_q[WIDTH-1];
        o_sd_valid   = 1'b1;
        o_busy       = 1'b1;
        o_first      = (cnt_q == '0);
        o_last       = at_last;
      end
      default: ;
    endcase

    accept = i_load_valid & o_load_ready;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = i_data;
          dir_d   = i_right;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (i_en) begin
          if (at_last) begin
            done_d = 1'b1;
            cnt_d  = '0;
            // a waiting word is taken on the last bit so frames run back to back
            if (accept) begin
              shreg_d = i_data;
              dir_d   = i_right;
            end else begin
              shreg_d = '0;
              state_d = ST_IDLE;
            end
          end else begin
            shreg_d = (dir_q == DIR_RIGHT) ? (shreg_q >> 1) : (shreg_q << 1);
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_done = done_q;

endmodule
